rev_gate_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit Feynman gate.
- Applies one of four 3-input reversible gates bitwise across WIDTH-bit operands: Feynman, Double Feynman, Toffoli or Fredkin.
- Gate is selected per transaction. Operands flow through a DEPTH-stage elastic valid/ready pipeline and an accepted-transaction counter is kept.
- Sits between an operand source and any downstream reversible-logic consumer or checker.

---
 rtl/rev_gate_pipe.sv | 137 +++++++++++++
 tb/tb_rev_gate_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rev_gate_pipe.sv
// rev_gate_pipe: bitwise Feynman/Double-Feynman/Toffoli/Fredkin gate behind an elastic DEPTH-stage pipe.
// Optional self-check datapath enabled by defining REV_GATE_CHECK_EN.
`default_nettype none

module rev_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [1:0]       out_mode,
`ifdef REV_GATE_CHECK_EN
  input  logic             inj_fault,
  output logic             check_err,
  output logic             sticky_err,
`endif
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] c_MODE_FG  = 2'b00;
  localparam logic [1:0] c_MODE_DFG = 2'b01;
  localparam logic [1:0] c_MODE_TG  = 2'b10;
`ifdef REV_GATE_CHECK_EN
  localparam int c_PW = 6*WIDTH + 2;
`else
  localparam int c_PW = 3*WIDTH + 2;
`endif

  function automatic logic [3*WIDTH-1:0] f_gate(input logic [1:0] m,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
    logic [3*WIDTH-1:0] y;
    case (m)
      c_MODE_FG:  y = {a, a ^ b, c};
      c_MODE_DFG: y = {a, a ^ b, a ^ c};
      c_MODE_TG:  y = {a, b, c ^ (a & b)};
      default:    y = {a, (a & c) | (~a & b), (a & b) | (~a & c)};
    endcase
    return y;
  endfunction

  logic [3*WIDTH-1:0] w_gate;
  logic [WIDTH-1:0]   w_q_in;
  logic [c_PW-1:0]    w_pay_in;
  logic [DEPTH-1:0]   w_adv;
  logic [DEPTH-1:0]   w_load;
  logic [DEPTH-1:0]   r_vld;
  logic [c_PW-1:0]    r_pay [DEPTH];
  logic [CNT_W-1:0]   r_cnt;

  assign w_gate = f_gate(in_mode, in_a, in_b, in_c);
`ifdef REV_GATE_CHECK_EN
  assign w_q_in   = w_gate[2*WIDTH-1:WIDTH] ^ WIDTH'(inj_fault);
  assign w_pay_in = {in_a, in_b, in_c, in_mode, w_gate[3*WIDTH-1:2*WIDTH], w_q_in, w_gate[WIDTH-1:0]};
`else
  assign w_q_in   = w_gate[2*WIDTH-1:WIDTH];
  assign w_pay_in = {in_mode, w_gate[3*WIDTH-1:2*WIDTH], w_q_in, w_gate[WIDTH-1:0]};
`endif

  // Advance is resolved from the output back toward stage 0 so bubbles fill under stall.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = r_vld[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_adv[k] = r_vld[k] & (~r_vld[k+1] | w_adv[k+1]);
    end
    w_load = ~r_vld | w_adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_pay[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_pay[0] <= w_pay_in;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_pay[k] <= r_pay[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_vld[DEPTH-1];
  assign op_count  = r_cnt;
  assign {out_mode, out_p, out_q, out_r} = r_pay[DEPTH-1][3*WIDTH+1:0];

`ifdef REV_GATE_CHECK_EN
  logic [3*WIDTH-1:0] w_rev;
  logic               w_mis;
  logic               r_sticky;

  // Every gate is self-inverse, so reapplying it must reproduce the carried operands.
  assign w_rev     = f_gate(out_mode, out_p, out_q, out_r);
  assign w_mis     = (w_rev != r_pay[DEPTH-1][c_PW-1 -: 3*WIDTH]);
  assign check_err = out_valid & w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (out_valid && out_ready && w_mis) begin
      r_sticky <= 1'b1;
    end
  end

  assign sticky_err = r_sticky;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rev_gate_pipe.sv
// tb_rev_gate_pipe: random and directed stimulus against a queue-based gate model.
`default_nettype none

module tb_rev_gate_pipe;
  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_mode, out_mode;
  logic [W-1:0]  in_a, in_b, in_c, out_p, out_q, out_r;
  logic [CW-1:0] op_count;
  logic          inj_fault;
`ifdef REV_GATE_CHECK_EN
  logic          check_err, sticky_err;
`endif

  always #5 clk = ~clk;

  rev_gate_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_q(out_q), .out_r(out_r), .out_mode(out_mode),
`ifdef REV_GATE_CHECK_EN
    .inj_fault(inj_fault), .check_err(check_err), .sticky_err(sticky_err),
`endif
    .op_count(op_count)
  );

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] p, q, r;
    logic         err;
    int           vis;
  } item_t;

  item_t        q_exp[$];
  int           n_cmp = 0, n_err = 0, e = 0, n_acc = 0, cnt_m = 0;
  logic         sticky_m = 1'b0;
  logic [W-1:0] last_p, last_q, last_r;

  // Reference gate evaluated bit by bit straight from the truth rules.
  function automatic logic [3*W-1:0] ref_gate(input logic [1:0] m, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] c);
    logic [W-1:0] p, q, r;
    for (int i = 0; i < W; i++) begin
      p[i] = a[i];
      case (m)
        2'd0:    begin q[i] = a[i] ^ b[i]; r[i] = c[i]; end
        2'd1:    begin q[i] = a[i] ^ b[i]; r[i] = a[i] ^ c[i]; end
        2'd2:    begin q[i] = b[i]; r[i] = c[i] ^ (a[i] & b[i]); end
        default: begin q[i] = a[i] ? c[i] : b[i]; r[i] = a[i] ? b[i] : c[i]; end
      endcase
    end
    return {p, q, r};
  endfunction

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model across the edge.
  task automatic cyc();
    logic exp_ov, exp_ir, fin, fout;
    logic [3*W-1:0] g;
    item_t it;
    #1;
    exp_ov = (q_exp.size() > 0) && (e >= q_exp[0].vis);
    exp_ir = !(q_exp.size() == D && !out_ready);
    chk(64'(out_valid), 64'(exp_ov), "out_valid");
    chk(64'(in_ready), 64'(exp_ir), "in_ready");
    chk(64'(op_count), 64'(cnt_m), "op_count");
    if (exp_ov) begin
      chk(64'(out_p), 64'(q_exp[0].p), "out_p");
      chk(64'(out_q), 64'(q_exp[0].q), "out_q");
      chk(64'(out_r), 64'(q_exp[0].r), "out_r");
      chk(64'(out_mode), 64'(q_exp[0].m), "out_mode");
    end
`ifdef REV_GATE_CHECK_EN
    chk(64'(check_err), 64'(exp_ov && q_exp[0].err), "check_err");
    chk(64'(sticky_err), 64'(sticky_m), "sticky_err");
`endif
    fin  = in_valid && exp_ir;
    fout = exp_ov && out_ready;
    if (fout) begin
      last_p = out_p; last_q = out_q; last_r = out_r;
    end
    if (fin) begin
      g    = ref_gate(in_mode, in_a, in_b, in_c);
      it.m = in_mode;
      it.p = g[3*W-1:2*W];
      it.q = g[2*W-1:W] ^ W'(inj_fault);
      it.r = g[W-1:0];
      it.err = inj_fault;
      it.vis = e + D;
    end
    @(posedge clk);
    e++;
    if (fout) begin
      sticky_m = sticky_m | q_exp[0].err;
      void'(q_exp.pop_front());
      if (q_exp.size() > 0 && q_exp[0].vis < e) q_exp[0].vis = e;
    end
    if (fin) begin
      q_exp.push_back(it);
      cnt_m = (cnt_m + 1) % (1 << CW);
      n_acc++;
    end
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c);
    int start;
    start = n_acc;
    in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_c = c;
    for (int g = 0; g < 40 && n_acc == start; g++) cyc();
    if (n_acc == start) chk(64'(0), 64'(1), "accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < 40 && q_exp.size() > 0; g++) cyc();
    if (q_exp.size() > 0) chk(64'(0), 64'(1), "drain_timeout");
    cyc();
  endtask

  task automatic chk_reset_state(input string tag);
    chk(64'(out_valid), 64'(0), {tag, "_valid"});
    chk(64'(op_count), 64'(0), {tag, "_count"});
    chk(64'({out_p, out_q, out_r, out_mode}), 64'(0), {tag, "_data"});
    chk(64'(in_ready), 64'(1), {tag, "_ready"});
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_state("rst");
    q_exp.delete(); cnt_m = 0; sticky_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inj_fault = 1'b0;
    in_mode = '0; in_a = '0; in_b = '0; in_c = '0;
    #2 chk_reset_state("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(2'b00, 8'hF0, 8'h3C, 8'hAA); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'hF0CCAA), "fg_vec");
    send(2'b01, 8'hF0, 8'h3C, 8'hAA); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'hF0CC5A), "dfg_vec");
    send(2'b10, 8'h0F, 8'h33, 8'h55); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'h0F3356), "tg_vec");
    send(2'b10, last_p, last_q, last_r); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'h0F3355), "tg_inverse");
    send(2'b11, 8'h0F, 8'h33, 8'h55); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'h0F3553), "frg_vec");
    send(2'b11, last_p, last_q, last_r); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'h0F3355), "frg_inverse");

    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send(2'(i), W'($urandom), W'($urandom), W'($urandom));
    in_valid = 1'b1; in_mode = 2'b11; in_a = 8'h5A; in_b = 8'h12; in_c = 8'h34;
    repeat (3) cyc();
    chk(64'(in_ready), 64'(0), "bp_in_ready");
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) send(2'(i), W'($urandom), W'($urandom), W'($urandom));
    drain();
    chk(64'(op_count), 64'(6), "bp_count");

    out_ready = 1'b0;
    send(2'b10, 8'h11, 8'h22, 8'h33); send(2'b01, 8'h44, 8'h55, 8'h66);
    #3 rst_n = 1'b0;
    #1 chk_reset_state("mid_rst");
    q_exp.delete(); cnt_m = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b00, 8'hF0, 8'h3C, 8'hAA); drain();
    chk(64'({last_p, last_q, last_r}), 64'(24'hF0CCAA), "post_rst_vec");

    do_reset();
    for (int i = 0; i < 17; i++) send(2'($urandom), W'($urandom), W'($urandom), W'($urandom));
    drain();
    chk(64'(op_count), 64'(1), "wrap_count");

    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      in_mode   = 2'($urandom);
      in_a = W'($urandom); in_b = W'($urandom); in_c = W'($urandom);
      cyc();
    end
    drain();

`ifdef REV_GATE_CHECK_EN
    do_reset();
    send(2'b11, 8'hA5, 8'h0F, 8'hF0);
    inj_fault = 1'b1; send(2'b10, 8'h3C, 8'h66, 8'h99); inj_fault = 1'b0;
    send(2'b01, 8'h12, 8'h34, 8'h56);
    drain();
    chk(64'(sticky_err), 64'(1), "sticky_set");
    do_reset();
    chk(64'(sticky_err), 64'(0), "sticky_clr");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
